// File: rtl/bfloat16_to_int16.sv
// Sequential bfloat16 -> int16 converter: classify, align one bit per cycle,
// round to nearest-even, saturate, then report with a one-cycle done pulse.
module bfloat16_to_int16 (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] in_bf16,
  input  logic        start,
  output logic        ready,
  output logic        done,
  output logic [15:0] result,
  output logic        invalid,
  output logic        overflow,
  output logic        inexact
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 7;
  localparam int unsigned CNT_W  = 4;

  // Exponent at which {1,mant} is already the integer value (2^7 scaling)
  localparam logic [EXP_W-1:0] EXP_ALIGN = 8'd134;
  localparam logic [EXP_W-1:0] EXP_HALF  = 8'd126;
  localparam logic [EXP_W-1:0] EXP_SAT   = 8'd142;
  localparam logic [EXP_W-1:0] EXP_MAX   = 8'd255;
  localparam logic [DATA_W-1:0] POS_SAT  = 16'h7FFF;
  localparam logic [DATA_W-1:0] NEG_SAT  = 16'h8000;
  localparam logic [DATA_W-1:0] NEG_MIN_BF16 = 16'hC700;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  op;
  logic [DATA_W-1:0]  w;
  logic               g;
  logic               s;
  logic               shift_left;
  logic [CNT_W-1:0]   cnt;

  logic               op_sign;
  logic [EXP_W-1:0]   op_exp;
  logic [MANT_W-1:0]  op_mant;
  logic [EXP_W-1:0]   shift_amt;
  logic               round_up;
  logic [DATA_W-1:0]  w_rnd;

  assign op_sign   = op[DATA_W-1];
  assign op_exp    = op[DATA_W-2 -: EXP_W];
  assign op_mant   = op[MANT_W-1:0];
  assign shift_amt = (op_exp < EXP_ALIGN) ? EXP_W'(EXP_ALIGN - op_exp)
                                          : EXP_W'(op_exp - EXP_ALIGN);
  assign round_up  = g & (s | w[0]);
  assign w_rnd     = w + DATA_W'(round_up);

  // Single-process FSM; result and flags load only on entry to DONE
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      op         <= '0;
      w          <= '0;
      g          <= 1'b0;
      s          <= 1'b0;
      shift_left <= 1'b0;
      cnt        <= '0;
      ready      <= 1'b1;
      done       <= 1'b0;
      result     <= '0;
      invalid    <= 1'b0;
      overflow   <= 1'b0;
      inexact    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op    <= in_bf16;
            ready <= 1'b0;
            state <= CLASSIFY;
          end
        end

        CLASSIFY: begin
          if (op_exp >= EXP_HALF && op_exp < EXP_SAT) begin
            w          <= DATA_W'({1'b1, op_mant});
            g          <= 1'b0;
            s          <= 1'b0;
            shift_left <= (op_exp > EXP_ALIGN);
            cnt        <= CNT_W'(shift_amt);
            state      <= (shift_amt == '0) ? ROUND : SHIFT;
          end else begin
            state    <= DONE;
            done     <= 1'b1;
            result   <= '0;
            invalid  <= 1'b0;
            overflow <= 1'b0;
            inexact  <= 1'b0;
            if (op_exp == EXP_MAX) begin
              if (op_mant != '0) begin
                invalid <= 1'b1;
              end else begin
                overflow <= 1'b1;
                result   <= op_sign ? NEG_SAT : POS_SAT;
              end
            end else if (op_exp >= EXP_SAT) begin
              // -32768 is representable exactly; everything else here saturates
              if (op == NEG_MIN_BF16) begin
                result <= NEG_SAT;
              end else begin
                overflow <= 1'b1;
                result   <= op_sign ? NEG_SAT : POS_SAT;
              end
            end else if (op_exp == '0) begin
              inexact <= (op_mant != '0);
            end else begin
              inexact <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (shift_left) begin
            w <= w << 1;
          end else begin
            s <= s | g;
            g <= w[0];
            w <= w >> 1;
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ROUND;
          end
        end

        ROUND: begin
          result   <= op_sign ? DATA_W'(~w_rnd + DATA_W'(1)) : w_rnd;
          invalid  <= 1'b0;
          overflow <= 1'b0;
          inexact  <= g | s;
          done     <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
